// File: rtl/regstr_bank.sv
// regstr_bank: DEPTH independent WIDTH-bit counter/scratch registers.
// Each register can be loaded, incremented, decremented or cleared.
// Arithmetic is wrap-around (SAT=0) or saturating (SAT=1). Each channel
// has a sticky overflow/underflow flag. The read port is registered.
//
// Ports:
//   clk     - clock, rising edge active
//   rst_a   - asynchronous reset, active-low (clears regs, ovf, rd_data)
//   rst_s   - synchronous clear of every register and ovf flag
//   sel     - channel targeted by we/inc/dec (ignored when >= DEPTH)
//   we      - load inp into reg[sel], clears ovf[sel]
//   inc     - reg[sel] + 1 (inc and dec together = hold)
//   dec     - reg[sel] - 1
//   inp     - load data
//   rd_sel  - read-port channel select
//   rd_data - registered read data (pre-update value of reg[rd_sel])
//   ovf     - sticky overflow/underflow flag per channel
//   zero    - combinational, bit i set when reg[i] == 0
module regstr_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SAT   = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             rst_s,
  input  logic [AW-1:0]    sel,
  input  logic             we,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] inp,
  input  logic [AW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH-1:0] ovf,
  output logic [DEPTH-1:0] zero
);

  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Returns {boundary_hit, next_value} for an increment.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] v);
    if (v == MAXV) return {1'b1, (SAT != 0) ? MAXV : '0};
    return {1'b0, v + WIDTH'(1)};
  endfunction

  // Returns {boundary_hit, next_value} for a decrement.
  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] v);
    if (v == '0) return {1'b1, (SAT != 0) ? '0 : MAXV};
    return {1'b0, v - WIDTH'(1)};
  endfunction

  always_comb begin
    logic [WIDTH:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      ovf_d[i]  = ovf_q[i];
      if (rst_s) begin
        regs_d[i] = '0;
        ovf_d[i]  = 1'b0;
      // Comparing against each in-range index means sel >= DEPTH matches nothing.
      end else if (sel == AW'(i)) begin
        if (we) begin
          regs_d[i] = inp;
          ovf_d[i]  = 1'b0;
        end else if (inc && !dec) begin
          res       = step_up(regs_q[i]);
          regs_d[i] = res[WIDTH-1:0];
          if (res[WIDTH]) ovf_d[i] = 1'b1;
        end else if (dec && !inc) begin
          res       = step_down(regs_q[i]);
          regs_d[i] = res[WIDTH-1:0];
          if (res[WIDTH]) ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Read-before-write: sample current contents; out-of-range select reads 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_sel == AW'(i)) rd_data_d = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) zero[i] = (regs_q[i] == '0);
  end

  assign ovf     = ovf_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regstr_bank.sv
// Testbench for regstr_bank: three instances share one stimulus stream
// (WIDTH=8): wrap-around DEPTH=4, saturating DEPTH=4, wrap-around DEPTH=3.
module tb_regstr_bank;

  logic       clk = 1'b0;
  logic       rst_a, rst_s, we, inc, dec;
  logic [1:0] sel, rd_sel;
  logic [7:0] inp;

  logic [7:0] rd_w, rd_s, rd_3;
  logic [3:0] ovf_w, zero_w, ovf_s, zero_s;
  logic [2:0] ovf_3, zero_3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regstr_bank #(.WIDTH(8), .DEPTH(4), .SAT(0)) u_wrap (
    .clk(clk), .rst_a(rst_a), .rst_s(rst_s), .sel(sel), .we(we), .inc(inc),
    .dec(dec), .inp(inp), .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w), .zero(zero_w));

  regstr_bank #(.WIDTH(8), .DEPTH(4), .SAT(1)) u_sat (
    .clk(clk), .rst_a(rst_a), .rst_s(rst_s), .sel(sel), .we(we), .inc(inc),
    .dec(dec), .inp(inp), .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s), .zero(zero_s));

  regstr_bank #(.WIDTH(8), .DEPTH(3), .SAT(0)) u_d3 (
    .clk(clk), .rst_a(rst_a), .rst_s(rst_s), .sel(sel), .we(we), .inc(inc),
    .dec(dec), .inp(inp), .rd_sel(rd_sel), .rd_data(rd_3), .ovf(ovf_3), .zero(zero_3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic w, input logic i, input logic d,
                    input logic [1:0] s, input logic [7:0] data);
    we = w; inc = i; dec = d; sel = s; inp = data; rst_s = 1'b0;
    step();
  endtask

  task automatic idle_rd(input logic [1:0] r);
    we = 1'b0; inc = 1'b0; dec = 1'b0; rst_s = 1'b0; rd_sel = r;
    step();
  endtask

  initial begin
    rst_a = 1'b1; rst_s = 1'b0; we = 1'b1; inc = 1'b0; dec = 1'b0;
    sel = 2'd2; inp = 8'hA5; rd_sel = 2'd2;

    // 1: reset with a pending load, then release and load
    #3 rst_a = 1'b0;
    step();
    step();
    chk("rst_zero", zero_w, 4'b1111);
    chk("rst_ovf", ovf_w, 4'b0000);
    chk("rst_rd", rd_w, 8'h00);
    rst_a = 1'b1;
    step();
    chk("t1_zero", zero_w, 4'b1011);
    chk("t1_zero_d3", zero_3, 3'b011);
    idle_rd(2'd2);
    chk("t1_rd", rd_w, 8'hA5);

    // 2: wrap-around boundaries and ovf clear by load
    op(1, 0, 0, 2'd1, 8'hFF);
    op(0, 1, 0, 2'd1, 8'h00);
    chk("t2_inc_zero", zero_w[1], 1'b1);
    chk("t2_inc_ovf", ovf_w, 4'b0010);
    chk("t2_sat_ovf", ovf_s, 4'b0010);
    chk("t2_sat_zero", zero_s[1], 1'b0);
    idle_rd(2'd1);
    chk("t2_rd_wrap", rd_w, 8'h00);
    chk("t2_rd_sat", rd_s, 8'hFF);
    op(1, 0, 0, 2'd1, 8'h00);
    chk("t2_we_clr", ovf_w, 4'b0000);
    op(0, 0, 1, 2'd1, 8'h00);
    chk("t2_dec_ovf", ovf_w, 4'b0010);
    idle_rd(2'd1);
    chk("t2_dec_rd", rd_w, 8'hFF);

    // 3: saturating increments and decrement at zero
    rd_sel = 2'd3;
    op(1, 0, 0, 2'd3, 8'hFE);
    op(0, 1, 0, 2'd3, 8'h00);
    chk("t3_inc1_rd", rd_s, 8'hFE);
    chk("t3_inc1_ovf", ovf_s[3], 1'b0);
    op(0, 1, 0, 2'd3, 8'h00);
    chk("t3_inc2_rd", rd_s, 8'hFF);
    chk("t3_inc2_ovf", ovf_s[3], 1'b1);
    op(0, 1, 0, 2'd3, 8'h00);
    chk("t3_inc3_rd", rd_s, 8'hFF);
    idle_rd(2'd3);
    chk("t3_hold_rd", rd_s, 8'hFF);
    chk("t3_hold_ovf", ovf_s[3], 1'b1);
    op(1, 0, 0, 2'd3, 8'h00);
    chk("t3_we_clr", ovf_s[3], 1'b0);
    op(0, 0, 1, 2'd3, 8'h00);
    chk("t3_dec_ovf_sat", ovf_s[3], 1'b1);
    chk("t3_dec_ovf_wrap", ovf_w[3], 1'b1);
    idle_rd(2'd3);
    chk("t3_dec_rd_sat", rd_s, 8'h00);
    chk("t3_dec_rd_wrap", rd_w, 8'hFF);

    // 4: inc+dec holds, load beats inc
    op(1, 0, 0, 2'd0, 8'h10);
    op(0, 1, 1, 2'd0, 8'h00);
    idle_rd(2'd0);
    chk("t4_incdec", rd_w, 8'h10);
    op(1, 1, 0, 2'd0, 8'h33);
    idle_rd(2'd0);
    chk("t4_we_wins", rd_w, 8'h33);
    chk("t4_ovf", ovf_w[0], 1'b0);

    // 5: synchronous clear beats load; rd_data shows pre-clear value
    op(1, 0, 0, 2'd0, 8'h05);
    op(1, 0, 0, 2'd1, 8'h06);
    op(1, 0, 0, 2'd2, 8'hFF);
    op(1, 0, 0, 2'd3, 8'h08);
    for (int k = 0; k < 8; k++) op(0, 1, 0, 2'd2, 8'h00);
    idle_rd(2'd2);
    chk("t5_pre_rd", rd_w, 8'h07);
    chk("t5_pre_ovf", ovf_w, 4'b0100);
    we = 1'b1; sel = 2'd0; inp = 8'h99; rst_s = 1'b1; rd_sel = 2'd3;
    step();
    chk("t5_clr_rd", rd_w, 8'h08);
    chk("t5_clr_ovf", ovf_w, 4'b0000);
    chk("t5_clr_zero", zero_w, 4'b1111);
    idle_rd(2'd3);
    chk("t5_after_rd", rd_w, 8'h00);

    // 6: DEPTH=3 ignores sel=3 and reads 0 there
    op(1, 0, 0, 2'd0, 8'h11);
    op(1, 0, 0, 2'd1, 8'h22);
    op(1, 0, 0, 2'd2, 8'h33);
    op(1, 0, 0, 2'd3, 8'h77);
    chk("t6_zero_d3", zero_3, 3'b000);
    op(0, 1, 0, 2'd3, 8'h00);
    chk("t6_ovf_d3", ovf_3, 3'b000);
    idle_rd(2'd3);
    chk("t6_rd3_d3", rd_3, 8'h00);
    chk("t6_rd3_wrap", rd_w, 8'h78);
    idle_rd(2'd0);
    chk("t6_rd0_d3", rd_3, 8'h11);
    idle_rd(2'd2);
    chk("t6_rd2_d3", rd_3, 8'h33);

    // Asynchronous reset in the middle of counting
    op(0, 1, 0, 2'd0, 8'h00);
    op(0, 1, 0, 2'd0, 8'h00);
    #2 rst_a = 1'b0;
    #1;
    chk("async_zero", zero_w, 4'b1111);
    chk("async_zero_d3", zero_3, 3'b111);
    chk("async_rd", rd_w, 8'h00);
    we = 1'b0; inc = 1'b0;
    step();
    rst_a = 1'b1;
    step();
    chk("async_hold", zero_w, 4'b1111);
    chk("async_ovf", ovf_w, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
